// File: rtl/r4u1_twiddle_pkg.sv
// Shared fixed-point constants and helpers for the radix-4 unit-1 datapath.
// Symmetric rounding, range test and group-size decode live here.
package r4u1_twiddle_pkg;

    localparam int MAN_WIDTH  = 16;
    localparam int EXP_WIDTH  = 6;
    localparam int TW_WIDTH   = 16;
    localparam int PROD_WIDTH = MAN_WIDTH + TW_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;

    // Quarter-group size: 4 for even log2 sizes, 8 for odd or illegal ones.
    function automatic logic [3:0] n_div_4(input logic [3:0] ldn);
        if (ldn >= 4'd4 && ldn <= 4'd11 && !ldn[0])
            return 4'd4;
        return 4'd8;
    endfunction

    // Arithmetic shift right by sh with ties rounded away from zero.
    function automatic logic signed [SUM_WIDTH-1:0] sym_round(
        input logic signed [SUM_WIDTH-1:0] x,
        input int                          sh
    );
        logic signed [SUM_WIDTH-1:0] half;
        logic signed [SUM_WIDTH-1:0] bias;
        half = $signed({{(SUM_WIDTH-1){1'b0}}, 1'b1} << (sh - 1));
        bias = half - $signed({{(SUM_WIDTH-1){1'b0}}, x[SUM_WIDTH-1]});
        return (x + bias) >>> sh;
    endfunction

    // True when x is representable as a MAN_WIDTH-bit signed mantissa.
    function automatic logic fits_man(input logic signed [SUM_WIDTH-1:0] x);
        logic [SUM_WIDTH-MAN_WIDTH:0] top;
        top = x[SUM_WIDTH-1:MAN_WIDTH-1];
        return (&top) | (~|top);
    endfunction

endpackage

// File: rtl/r4u1_twiddle_mult_rom.sv
// 32-point twiddle table: cos and -sin of 2*pi*m/32 in Q2.14.
// Only the first quarter is stored; the rest follows by symmetry.
module r4u1_twiddle_rom
    import r4u1_twiddle_pkg::*;
(
    input  logic        [4:0]          m32,
    output logic signed [TW_WIDTH-1:0] cos_w,
    output logic signed [TW_WIDTH-1:0] msin_w
);

    function automatic logic signed [TW_WIDTH-1:0] qcos(input logic [3:0] k);
        unique case (k)
            4'd0:    return 16'sd16384;
            4'd1:    return 16'sd16069;
            4'd2:    return 16'sd15137;
            4'd3:    return 16'sd13623;
            4'd4:    return 16'sd11585;
            4'd5:    return 16'sd9102;
            4'd6:    return 16'sd6270;
            4'd7:    return 16'sd3196;
            default: return 16'sd0;
        endcase
    endfunction

    logic [3:0] r_lo;
    logic [3:0] r_hi;

    // Fold the index into the first quadrant and restore signs.
    always_comb begin
        r_lo   = {1'b0, m32[2:0]};
        r_hi   = 4'd8 - r_lo;
        cos_w  = '0;
        msin_w = '0;
        unique case (m32[4:3])
            2'd0: begin cos_w =  qcos(r_lo); msin_w = -qcos(r_hi); end
            2'd1: begin cos_w = -qcos(r_hi); msin_w = -qcos(r_lo); end
            2'd2: begin cos_w = -qcos(r_lo); msin_w =  qcos(r_hi); end
            2'd3: begin cos_w =  qcos(r_hi); msin_w =  qcos(r_lo); end
        endcase
    end

endmodule

// File: rtl/r4u1_twiddle_mult.sv
// Unit-1 twiddle multiplier: BFP sample times W_L^(n*q), 3-cycle pipeline.
// Renormalises by one bit and bumps the exponent when the product overflows.
module r4u1_twiddle_mult
    import r4u1_twiddle_pkg::*;
(
    input  logic                        clk_sys,
    input  logic                        rst_sys,
    input  logic                        block_sync_i,
    input  logic                        next_sync_i,
    input  logic                        data_val_i,
    input  logic signed [MAN_WIDTH-1:0] data_real_i,
    input  logic signed [MAN_WIDTH-1:0] data_imag_i,
    input  logic signed [EXP_WIDTH-1:0] data_exp_i,
    input  logic        [3:0]           ldn_rg_i,
    input  logic                        k1_i,
    input  logic                        k2_i,
    output logic                        block_sync_o,
    output logic                        next_sync_o,
    output logic                        data_val_o,
    output logic signed [MAN_WIDTH-1:0] data_real_o,
    output logic signed [MAN_WIDTH-1:0] data_imag_o,
    output logic signed [EXP_WIDTH-1:0] data_exp_o
);

    logic [2:0] n_cnt;
    logic [1:0] q_reg;
    logic       armed;
    logic [3:0] nd4;
    logic [2:0] n_cur;
    logic [1:0] q_cur;
    logic [4:0] nq;
    logic [4:0] m32;
    logic       v_in;

    logic signed [TW_WIDTH-1:0] tw_cos;
    logic signed [TW_WIDTH-1:0] tw_msin;

    logic                         s1_v, s1_bs, s1_ns;
    logic signed [MAN_WIDTH-1:0]  s1_re, s1_im;
    logic signed [EXP_WIDTH-1:0]  s1_exp;
    logic signed [TW_WIDTH-1:0]   s1_c, s1_s;

    logic                         s2_v, s2_bs, s2_ns;
    logic signed [EXP_WIDTH-1:0]  s2_exp;
    logic signed [PROD_WIDTH-1:0] p_ac, p_bd, p_ad, p_bc;

    logic signed [SUM_WIDTH-1:0]  re_sum, im_sum;
    logic signed [SUM_WIDTH-1:0]  re_r, im_r, re_r1, im_r1;
    logic signed [SUM_WIDTH-1:0]  re_out, im_out;
    logic                         ovf;

    // Current sample/group index and the resulting table index.
    always_comb begin
        nd4   = n_div_4(ldn_rg_i);
        n_cur = next_sync_i ? 3'd0 : n_cnt;
        q_cur = next_sync_i ? {k2_i, k1_i} : q_reg;
        nq    = {2'b00, n_cur} * {3'b000, q_cur};
        m32   = (nd4 == 4'd4) ? {nq[3:0], 1'b0} : nq;
        v_in  = data_val_i & (next_sync_i | armed);
    end

    r4u1_twiddle_rom u_rom (
        .m32    (m32),
        .cos_w  (tw_cos),
        .msin_w (tw_msin)
    );

    // Sample counter and group register; disarmed by reset until next group.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            n_cnt <= '0;
            q_reg <= '0;
            armed <= 1'b0;
        end else if (data_val_i) begin
            if (next_sync_i) begin
                n_cnt <= 3'd1;
                q_reg <= {k2_i, k1_i};
                armed <= 1'b1;
            end else if ({1'b0, n_cnt} == nd4 - 4'd1) begin
                n_cnt <= 3'd0;
            end else begin
                n_cnt <= n_cnt + 3'd1;
            end
        end
    end

    // S1: capture sample, exponent, syncs and looked-up twiddle.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            s1_v   <= 1'b0;
            s1_bs  <= 1'b0;
            s1_ns  <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            s1_exp <= '0;
            s1_c   <= '0;
            s1_s   <= '0;
        end else begin
            s1_v   <= v_in;
            s1_bs  <= block_sync_i & v_in;
            s1_ns  <= next_sync_i & v_in;
            s1_re  <= data_real_i;
            s1_im  <= data_imag_i;
            s1_exp <= data_exp_i;
            s1_c   <= tw_cos;
            s1_s   <= tw_msin;
        end
    end

    // S2: the four partial products.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            s2_v   <= 1'b0;
            s2_bs  <= 1'b0;
            s2_ns  <= 1'b0;
            s2_exp <= '0;
            p_ac   <= '0;
            p_bd   <= '0;
            p_ad   <= '0;
            p_bc   <= '0;
        end else begin
            s2_v   <= s1_v;
            s2_bs  <= s1_bs;
            s2_ns  <= s1_ns;
            s2_exp <= s1_exp;
            p_ac   <= PROD_WIDTH'(s1_re) * PROD_WIDTH'(s1_c);
            p_bd   <= PROD_WIDTH'(s1_im) * PROD_WIDTH'(s1_s);
            p_ad   <= PROD_WIDTH'(s1_re) * PROD_WIDTH'(s1_s);
            p_bc   <= PROD_WIDTH'(s1_im) * PROD_WIDTH'(s1_c);
        end
    end

    // S3 combine: complex sum, rounding, one-bit renormalisation on overflow.
    always_comb begin
        re_sum = $signed({p_ac[PROD_WIDTH-1], p_ac})
               - $signed({p_bd[PROD_WIDTH-1], p_bd});
        im_sum = $signed({p_ad[PROD_WIDTH-1], p_ad})
               + $signed({p_bc[PROD_WIDTH-1], p_bc});
        re_r   = sym_round(re_sum, TW_WIDTH - 2);
        im_r   = sym_round(im_sum, TW_WIDTH - 2);
        re_r1  = sym_round(re_sum, TW_WIDTH - 1);
        im_r1  = sym_round(im_sum, TW_WIDTH - 1);
        ovf    = !fits_man(re_r) || !fits_man(im_r);
        re_out = ovf ? re_r1 : re_r;
        im_out = ovf ? im_r1 : im_r;
    end

    // S3 register: outputs, data forced to zero on bubbles.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            data_val_o   <= 1'b0;
            block_sync_o <= 1'b0;
            next_sync_o  <= 1'b0;
            data_real_o  <= '0;
            data_imag_o  <= '0;
            data_exp_o   <= '0;
        end else begin
            data_val_o   <= s2_v;
            block_sync_o <= s2_bs;
            next_sync_o  <= s2_ns;
            data_real_o  <= s2_v ? re_out[MAN_WIDTH-1:0] : '0;
            data_imag_o  <= s2_v ? im_out[MAN_WIDTH-1:0] : '0;
            data_exp_o   <= s2_v ? (s2_exp + EXP_WIDTH'(ovf)) : '0;
        end
    end

endmodule

// File: tb/tb_r4u1_twiddle_mult.sv
// Directed bench for r4u1_twiddle_mult with hand-computed vectors.
// Outputs are captured on the falling edge and matched in order.
module tb_r4u1_twiddle_mult;
    import r4u1_twiddle_pkg::*;

    typedef struct {
        int re;
        int im;
        int e;
        bit bs;
        bit ns;
        int cyc;
    } rec_t;

    logic                        clk_sys = 1'b0;
    logic                        rst_sys = 1'b0;
    logic                        block_sync_i = 1'b0;
    logic                        next_sync_i = 1'b0;
    logic                        data_val_i = 1'b0;
    logic signed [MAN_WIDTH-1:0] data_real_i = '0;
    logic signed [MAN_WIDTH-1:0] data_imag_i = '0;
    logic signed [EXP_WIDTH-1:0] data_exp_i = '0;
    logic        [3:0]           ldn_rg_i = 4'd4;
    logic                        k1_i = 1'b0;
    logic                        k2_i = 1'b0;
    logic                        block_sync_o;
    logic                        next_sync_o;
    logic                        data_val_o;
    logic signed [MAN_WIDTH-1:0] data_real_o;
    logic signed [MAN_WIDTH-1:0] data_imag_o;
    logic signed [EXP_WIDTH-1:0] data_exp_o;

    rec_t exp_q[$];
    rec_t out_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   idle_bad = 0;

    r4u1_twiddle_mult dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .block_sync_i (block_sync_i),
        .next_sync_i  (next_sync_i),
        .data_val_i   (data_val_i),
        .data_real_i  (data_real_i),
        .data_imag_i  (data_imag_i),
        .data_exp_i   (data_exp_i),
        .ldn_rg_i     (ldn_rg_i),
        .k1_i         (k1_i),
        .k2_i         (k2_i),
        .block_sync_o (block_sync_o),
        .next_sync_o  (next_sync_o),
        .data_val_o   (data_val_o),
        .data_real_o  (data_real_o),
        .data_imag_o  (data_imag_o),
        .data_exp_o   (data_exp_o)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (data_val_o)
            out_q.push_back('{int'(data_real_o), int'(data_imag_o),
                              int'(data_exp_o), block_sync_o,
                              next_sync_o, cyc});
        else if (data_real_o != 0 || data_imag_o != 0 || data_exp_o != 0 ||
                 block_sync_o || next_sync_o)
            idle_bad++;
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send(input bit v, input bit bs, input bit ns,
                        input bit k1, input bit k2,
                        input int re, input int im, input int e,
                        input bit o, input int ere, input int eim,
                        input int ee);
        @(posedge clk_sys);
        #1;
        data_val_i   = v;
        block_sync_i = bs;
        next_sync_i  = ns;
        k1_i         = k1;
        k2_i         = k2;
        data_real_i  = MAN_WIDTH'(re);
        data_imag_i  = MAN_WIDTH'(im);
        data_exp_i   = EXP_WIDTH'(e);
        if (v && o)
            exp_q.push_back('{ere, eim, ee, bs, ns, cyc});
    endtask

    task automatic idle();
        send(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        rec_t a;
        rec_t b;
        int   i;
        repeat (6) idle();
        chk($sformatf("%s.count", tag), out_q.size(), exp_q.size());
        i = 0;
        while (exp_q.size() > 0 && out_q.size() > 0) begin
            a = out_q.pop_front();
            b = exp_q.pop_front();
            chk($sformatf("%s[%0d].re", tag, i), a.re, b.re);
            chk($sformatf("%s[%0d].im", tag, i), a.im, b.im);
            chk($sformatf("%s[%0d].exp", tag, i), a.e, b.e);
            chk($sformatf("%s[%0d].bs", tag, i), int'(a.bs), int'(b.bs));
            chk($sformatf("%s[%0d].ns", tag, i), int'(a.ns), int'(b.ns));
            chk($sformatf("%s[%0d].lat", tag, i), a.cyc - b.cyc, 3);
            i++;
        end
        exp_q.delete();
        out_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".val"}, int'(data_val_o), 0);
        chk({tag, ".re"}, int'(data_real_o), 0);
        chk({tag, ".im"}, int'(data_imag_o), 0);
        chk({tag, ".exp"}, int'(data_exp_o), 0);
        chk({tag, ".bs"}, int'(block_sync_o), 0);
        chk({tag, ".ns"}, int'(next_sync_o), 0);
    endtask

    initial begin
        int qord [4];
        logic [1:0] qv;
        int re, im, ere, eim;
        qord = '{0, 2, 1, 3};

        #1 rst_sys = 1'b1;
        #1 chk_zero("reset");
        repeat (2) @(posedge clk_sys);
        #2 rst_sys = 1'b0;

        // L=16, q=1: n=0 passes through, n=1 rotates by W_32^2
        ldn_rg_i = 4'd4;
        send(1, 1, 1, 1, 0, 500, -200, 3, 1, 500, -200, 3);
        send(1, 0, 0, 1, 0, 1000, 0, 3, 1, 924, -383, 3);
        drain("l16_q1");

        // q=0 group: unity twiddle incl. full-scale extremes
        send(1, 0, 1, 0, 0, 32767, -32768, 7, 1, 32767, -32768, 7);
        send(1, 0, 0, 0, 0, -32767, 32767, 7, 1, -32767, 32767, 7);
        send(1, 0, 0, 0, 0, -32768, -32768, 7, 1, -32768, -32768, 7);
        send(1, 0, 0, 0, 0, 1, -1, 7, 1, 1, -1, 7);
        drain("l16_q0");

        // q=2, n=1 (m32=4): magnitude overflow forces renormalisation
        send(1, 0, 1, 0, 1, 100, 50, 0, 1, 100, 50, 0);
        send(1, 0, 0, 0, 1, 32767, 32767, 0, 1, 23169, 0, 1);
        drain("l16_ovf");

        // L=32 full block, group order 0,2,1,3, gaps carrying stray syncs
        ldn_rg_i = 4'd5;
        for (int g = 0; g < 4; g++) begin
            qv = 2'(qord[g]);
            for (int n = 0; n < 8; n++) begin
                re = 0; im = 0; ere = 0; eim = 0;
                if (qv == 2'd0) begin
                    re = 100 * n + 7; im = -50 * n; ere = re; eim = im;
                end
                if (qv == 2'd1 && n == 1) begin
                    re = 1000; ere = 981; eim = -195;
                end
                if (qv == 2'd2 && n == 1) begin
                    re = 1000; ere = 924; eim = -383;
                end
                if (qv == 2'd3 && n == 1) begin
                    re = 4096; ere = 3406; eim = -2276;
                end
                if (qv == 2'd3 && n == 2) begin
                    re = -4096; ere = -1568; eim = 3784;
                end
                if (qv == 2'd3 && n == 4) begin
                    im = 2000; ere = 1414; eim = -1414;
                end
                if (qv == 2'd3 && n == 7) begin
                    re = 4096; ere = -2276; eim = 3406;
                end
                send(1, (g == 0 && n == 0), (n == 0), qv[0], qv[1],
                     re, im, 2, 1, ere, eim, 2);
                if (n % 3 == 1)
                    send(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            end
        end
        drain("l32_blk");

        // Asynchronous reset mid-group with results on the outputs
        ldn_rg_i = 4'd4;
        send(1, 0, 1, 1, 0, 700, 0, 4, 1, 700, 0, 4);
        send(1, 0, 0, 1, 0, 1000, 0, 4, 0, 0, 0, 0);
        send(1, 0, 0, 1, 0, 1000, 0, 4, 0, 0, 0, 0);
        send(1, 0, 0, 1, 0, 1000, 0, 4, 0, 0, 0, 0);
        #5;
        chk("pre_rst.val", int'(data_val_o), 1);
        rst_sys = 1'b1;
        #1 chk_zero("mid_rst");
        @(posedge clk_sys);
        #2 rst_sys = 1'b0;
        send(1, 0, 0, 1, 1, 5000, 5000, 4, 0, 0, 0, 0);
        send(1, 0, 1, 1, 0, 300, 400, 4, 1, 300, 400, 4);
        send(1, 0, 0, 1, 0, 1000, 0, 4, 1, 924, -383, 4);
        drain("after_rst");

        chk("idle_zero", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
